serial_subtractor: RTL and testbench

Bit-serial N-bit subtractor computing `diff = a - b` LSB-first, one bit per clock, through a single one-bit full-subtractor cell and a borrow flip-flop. It is the arithmetic counterpart of the one-bit full adder in the combinational library. It sits in the sequential datapath library as an area-minimal alternative to a parallel ripple subtractor, with a start/done handshake for use under a controller FSM.

---
 rtl/serial_sub_pkg.sv | 19 +
 rtl/full_subtractor.sv | 15 +
 rtl/serial_subtractor.sv | 104 ++++++++++
 tb/tb_serial_subtractor.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: d = x - y - bin, borrow out on bo.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bo
);

    always_comb begin
        d  = x ^ y ^ bin;
        bo = (~x & y) | (~(x ^ y) & bin);
    end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, with start/done handshake.
// Define SERIAL_SUB_OVF_EN to add the signed-overflow output ovf.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned CW = clog2(WIDTH);
    localparam logic [CW-1:0] CntLast = CW'(WIDTH - 1);

    state_e           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-2:0] r_sr;
    logic             borrow;
    logic [CW-1:0]    cnt;
    logic             d;
    logic             bo;
    logic [WIDTH-1:0] r_next;

    full_subtractor u_cell (
        .x   (a_sr[0]),
        .y   (b_sr[0]),
        .bin (borrow),
        .d   (d),
        .bo  (bo)
    );

    // Only the upper WIDTH-1 result bits need storing; the last d completes the word.
    assign r_next = {d, r_sr};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            a_sr   <= '0;
            b_sr   <= '0;
            r_sr   <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            diff   <= '0;
            bout   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf    <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state  <= RUN;
                        a_sr   <= a;
                        b_sr   <= b;
                        borrow <= 1'b0;
                        cnt    <= '0;
                        busy   <= 1'b1;
                    end
                end
                RUN: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    r_sr   <= r_next[WIDTH-1:1];
                    borrow <= bo;
                    cnt    <= cnt + 1'b1;
                    if (cnt == CntLast) begin
                        state <= DONE;
                        done  <= 1'b1;
                        diff  <= r_next;
                        bout  <= bo;
`ifdef SERIAL_SUB_OVF_EN
                        ovf   <= (a_sr[0] ^ b_sr[0]) & (a_sr[0] ^ d);
`endif
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: arithmetic reference model plus directed vectors.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;
`ifdef SERIAL_SUB_OVF_EN
    logic         ovf;
`endif

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Reference model: counts edges since acceptance, result from plain integer arithmetic.
    bit           m_busy = 1'b0;
    int           m_p    = 0;
    logic [W-1:0] m_a    = '0;
    logic [W-1:0] m_b    = '0;
    logic [W-1:0] m_diff = '0;
    bit           m_bout = 1'b0;
    bit           m_ovf  = 1'b0;

    always @(posedge clk or posedge rst) begin
        int s;
        if (rst) begin
            m_busy = 1'b0; m_p = 0; m_diff = '0; m_bout = 1'b0; m_ovf = 1'b0;
        end else if (!m_busy) begin
            if (start === 1'b1) begin
                m_busy = 1'b1; m_p = 0; m_a = a; m_b = b;
            end
        end else begin
            m_p++;
            if (m_p == W) begin
                m_diff = W'(int'(m_a) - int'(m_b));
                m_bout = (m_a < m_b);
                s      = int'($signed(m_a)) - int'($signed(m_b));
                m_ovf  = (s < -(2 ** (W - 1))) || (s > 2 ** (W - 1) - 1);
            end else if (m_p == W + 1) begin
                m_busy = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_busy", 32'(busy), 32'(m_busy));
            check("model_done", 32'(done), 32'(m_busy && m_p == W));
            check("model_diff", 32'(diff), 32'(m_diff));
            check("model_bout", 32'(bout), 32'(m_bout));
`ifdef SERIAL_SUB_OVF_EN
            check("model_ovf", 32'(ovf), 32'(m_ovf));
`endif
        end
    end

    // Bounded wait for done; returns edges counted including the accepting edge (0 on timeout).
    task automatic wait_done(output int lat);
        lat = 0;
        for (int i = 1; i <= 20 && lat == 0; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1) lat = i + 1;
        end
    endtask

    task automatic op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic [W-1:0] ed,
                      input logic eb, input logic eo, input string nm);
        int lat;
        @(posedge clk); #2;
        a = av; b = bv; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0; a = ~av; b = ~bv;
        wait_done(lat);
        check({nm, "_latency"}, 32'(lat), 32'd9);
        check({nm, "_diff"}, 32'(diff), 32'(ed));
        check({nm, "_bout"}, 32'(bout), 32'(eb));
`ifdef SERIAL_SUB_OVF_EN
        check({nm, "_ovf"}, 32'(ovf), 32'(eo));
`else
        if (eo === 1'bx) $display("unused ovf expectation");
`endif
        @(posedge clk); #2;
    endtask

    initial begin
        int lat;
        int n_done;
        int t[$];
        #1 chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_diff", 32'(diff), 32'd0);
        check("rst_bout", 32'(bout), 32'd0);
        rst = 1'b0;

        op(8'd10,  8'd3,   8'd7,   1'b0, 1'b0, "10m3");
        op(8'd3,   8'd10,  8'hF9,  1'b1, 1'b0, "3m10");
        op(8'h80,  8'h01,  8'h7F,  1'b0, 1'b1, "80m01");
        op(8'h05,  8'h01,  8'h04,  1'b0, 1'b0, "05m01");
        op(8'h00,  8'h00,  8'h00,  1'b0, 1'b0, "00m00");
        op(8'hFF,  8'hFF,  8'h00,  1'b0, 1'b0, "FFmFF");
        op(8'h00,  8'hFF,  8'h01,  1'b1, 1'b0, "00mFF");

        // start pulses during RUN and during DONE must be ignored
        @(posedge clk); #2;
        a = 8'd40; b = 8'd2; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0; a = 8'd1; b = 8'd1;
        repeat (3) @(posedge clk);
        #2;
        a = 8'd99; b = 8'd9; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        wait_done(lat);
        check("ign_seen_done", 32'(lat != 0), 32'd1);
        #1;
        a = 8'd7; b = 8'd6; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        check("ign_diff", 32'(diff), 32'd38);
        n_done = 0;
        repeat (15) begin
            @(posedge clk); #1;
            if (done === 1'b1) n_done++;
        end
        check("ign_no_second_done", 32'(n_done), 32'd0);
        check("ign_diff_held", 32'(diff), 32'd38);

        // start held high: back-to-back results
        @(posedge clk); #2;
        a = 8'd50; b = 8'd8; start = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1) t.push_back(i);
        end
        #1 start = 1'b0;
        check("b2b_count_ge3", 32'(t.size() >= 3), 32'd1);
        if (t.size() >= 3) begin
            check("b2b_period1", 32'(t[1] - t[0]), 32'd10);
            check("b2b_period2", 32'(t[2] - t[1]), 32'd10);
        end
        check("b2b_diff", 32'(diff), 32'd42);
        repeat (12) @(posedge clk);

        // reset in RUN cycle 4 aborts and clears outputs
        #2;
        a = 8'h33; b = 8'h11; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_diff", 32'(diff), 32'd0);
        check("midrst_bout", 32'(bout), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
        check("midrst_ovf", 32'(ovf), 32'd0);
`endif
        @(posedge clk); #2;
        rst = 1'b0;
        op(8'd20, 8'd5, 8'd15, 1'b0, 1'b0, "20m5");

        repeat (3) @(posedge clk);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
